// File: rtl/bec_serial_rx_if.sv
// Handshake bundle for the (25,16) burst decoder: serial bit input side and decoded
// message output side. The decoder uses the slave view; the driver/consumer uses the master view.
interface bec_serial_rx_if;
    logic        in_bit;
    logic        in_valid;
    logic        in_ready;
    logic [0:15] out_msg;
    logic        out_valid;
    logic        out_ready;
    logic        out_corrected;
    logic        out_uncorrectable;

    modport master (
        output in_bit, in_valid, out_ready,
        input  in_ready, out_msg, out_valid, out_corrected, out_uncorrectable
    );

    modport slave (
        input  in_bit, in_valid, out_ready,
        output in_ready, out_msg, out_valid, out_corrected, out_uncorrectable
    );
endinterface

// File: rtl/bec_serial_rx.sv
// Serial receiver and sequential decoder for the (25,16) burst-error-correcting code (b<=4):
// deserialise, compute syndrome, 16-cycle burst-position search, valid/ready result.
module bec_serial_rx (
    input  logic           clk,
    input  logic           rst,
    bec_serial_rx_if.slave bus
);

    typedef enum logic [1:0] {
        ST_SHIFT  = 2'd0,
        ST_SYND   = 2'd1,
        ST_SEARCH = 2'd2,
        ST_OUT    = 2'd3
    } state_t;

    function automatic logic [0:8] f_parity(input logic [0:15] m);
        logic [0:8] p;
        p[0] = m[0] ^ m[4] ^ m[8]  ^ m[12];
        p[1] = m[1] ^ m[5] ^ m[9]  ^ m[13];
        p[2] = m[2] ^ m[6] ^ m[10] ^ m[14];
        p[3] = m[3] ^ m[7] ^ m[11] ^ m[15];
        p[4] = m[0] ^ m[2] ^ m[6]  ^ m[7]  ^ m[8]  ^ m[11];
        p[5] = m[0] ^ m[3] ^ m[6]  ^ m[9]  ^ m[12];
        p[6] = m[0] ^ m[1] ^ m[4]  ^ m[6]  ^ m[7]  ^ m[10] ^ m[13];
        p[7] = m[0] ^ m[2] ^ m[3]  ^ m[6]  ^ m[7]  ^ m[8]  ^ m[9]  ^ m[10] ^ m[14];
        p[8] = m[1] ^ m[2] ^ m[5]  ^ m[6]  ^ m[8]  ^ m[9]  ^ m[10] ^ m[11] ^ m[15];
        return p;
    endfunction

    function automatic logic [0:8] f_syndrome(input logic [0:24] c);
        return c[16:24] ^ f_parity(c[0:15]);
    endfunction

    // Candidate burst at start j: pattern bits come from the interleaved s[0:3] part.
    function automatic logic [0:24] f_burst(input logic [3:0] j, input logic [0:8] s);
        logic [0:24] e;
        e = 25'd0;
        for (int i = 0; i < 20; i++) begin
            if ((i >= int'(j)) && (i <= int'(j) + 3)) begin
                e[i] = s[i % 4];
            end
        end
        return e;
    endfunction

    function automatic logic [0:15] f_fix_msg(input logic [3:0] j, input logic [0:8] s);
        logic [0:24] e;
        e = f_burst(j, s);
        return e[0:15];
    endfunction

    // Syndrome positions tolerated because their parity bit (20+t) lies inside the window.
    function automatic logic [0:8] f_allowed(input logic [3:0] j);
        logic [0:8] mask;
        mask = 9'd0;
        for (int t = 0; t < 5; t++) begin
            if ((20 + t >= int'(j)) && (20 + t <= int'(j) + 3)) begin
                mask[4 + t] = 1'b1;
            end
        end
        return mask;
    endfunction

    function automatic logic f_parity_only(input logic [0:8] s);
        int lo;
        int hi;
        lo = 9;
        hi = -1;
        for (int t = 0; t < 9; t++) begin
            if (s[t]) begin
                if (lo == 9) begin
                    lo = t;
                end
                hi = t;
            end
        end
        return (hi >= 0) && ((hi - lo) <= 3);
    endfunction

    state_t      r_state;
    state_t      w_next_state;
    logic [4:0]  r_cnt;
    logic [0:24] r_cw;
    logic [0:8]  r_synd;
    logic [3:0]  r_j;
    logic        r_hit;
    logic [3:0]  r_hit_j;
    logic        r_in_ready;
    logic        r_out_valid;
    logic [0:15] r_out_msg;
    logic        r_corr;
    logic        r_unc;

    logic        w_beat;
    logic [0:8]  w_synd;
    logic [0:24] w_cand;
    logic        w_accept;
    logic [3:0]  w_sel_j;
    logic        w_found;
    logic [0:15] w_res_msg;
    logic        w_res_corr;
    logic        w_res_unc;

    // Next-state decode and end-of-search result selection.
    always_comb begin
        w_next_state = r_state;
        w_beat       = bus.in_valid & r_in_ready;
        w_synd       = f_syndrome(r_cw);
        w_cand       = f_burst(r_j, r_synd);
        w_accept     = ((f_syndrome(w_cand) ^ r_synd) & ~f_allowed(r_j)) == 9'd0;
        w_found      = r_hit | w_accept;
        w_sel_j      = r_hit ? r_hit_j : r_j;
        w_res_msg    = r_cw[0:15];
        w_res_corr   = 1'b0;
        w_res_unc    = 1'b0;

        if (w_found) begin
            w_res_msg  = r_cw[0:15] ^ f_fix_msg(w_sel_j, r_synd);
            w_res_corr = 1'b1;
        end else if (f_parity_only(r_synd)) begin
            w_res_corr = 1'b1;
        end else begin
            w_res_unc  = 1'b1;
        end

        case (r_state)
            ST_SHIFT: begin
                if (w_beat && (r_cnt == 5'd24)) begin
                    w_next_state = ST_SYND;
                end else begin
                    w_next_state = ST_SHIFT;
                end
            end
            ST_SYND: begin
                if (w_synd == 9'd0) begin
                    w_next_state = ST_OUT;
                end else begin
                    w_next_state = ST_SEARCH;
                end
            end
            ST_SEARCH: begin
                if (r_j == 4'd15) begin
                    w_next_state = ST_OUT;
                end else begin
                    w_next_state = ST_SEARCH;
                end
            end
            ST_OUT: begin
                if (bus.out_ready) begin
                    w_next_state = ST_SHIFT;
                end else begin
                    w_next_state = ST_OUT;
                end
            end
            default: w_next_state = ST_SHIFT;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_SHIFT;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Datapath: deserialiser, syndrome, search bookkeeping and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= 5'd0;
            r_cw        <= 25'd0;
            r_synd      <= 9'd0;
            r_j         <= 4'd0;
            r_hit       <= 1'b0;
            r_hit_j     <= 4'd0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_msg   <= 16'h0000;
            r_corr      <= 1'b0;
            r_unc       <= 1'b0;
        end else begin
            r_in_ready  <= (w_next_state == ST_SHIFT);
            r_out_valid <= (w_next_state == ST_OUT);
            case (r_state)
                ST_SHIFT: begin
                    if (w_beat) begin
                        r_cw[r_cnt] <= bus.in_bit;
                        r_cnt       <= (r_cnt == 5'd24) ? 5'd0 : r_cnt + 5'd1;
                    end
                end
                ST_SYND: begin
                    r_synd <= w_synd;
                    r_j    <= 4'd0;
                    r_hit  <= 1'b0;
                    if (w_synd == 9'd0) begin
                        r_out_msg <= r_cw[0:15];
                        r_corr    <= 1'b0;
                        r_unc     <= 1'b0;
                    end
                end
                ST_SEARCH: begin
                    r_j <= r_j + 4'd1;
                    if (w_accept && !r_hit) begin
                        r_hit   <= 1'b1;
                        r_hit_j <= r_j;
                    end
                    if (r_j == 4'd15) begin
                        r_out_msg <= w_res_msg;
                        r_corr    <= w_res_corr;
                        r_unc     <= w_res_unc;
                    end
                end
                ST_OUT: begin
                    r_j <= 4'd0;
                end
                default: begin
                    r_cnt <= 5'd0;
                end
            endcase
        end
    end

    assign bus.in_ready          = r_in_ready;
    assign bus.out_valid         = r_out_valid;
    assign bus.out_msg           = r_out_msg;
    assign bus.out_corrected     = r_corr;
    assign bus.out_uncorrectable = r_unc;

endmodule

// File: tb/tb_bec_serial_rx.sv
// Self-checking bench for bec_serial_rx: directed cases plus random codewords with
// injected bursts, checked against a mask-based behavioural decoder model.
module tb_bec_serial_rx;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    bec_serial_rx_if bus_if();

    bec_serial_rx dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    // Parity-check rows: bit i (from the left) set when m[i] feeds that parity bit.
    localparam logic [0:15] PMASK [0:8] = '{
        16'h8888, 16'h4444, 16'h2222, 16'h1111,
        16'hA390, 16'h9248, 16'hCB24, 16'hB3E2, 16'h66F1
    };

    function automatic logic [0:8] m_parity(input logic [0:15] m);
        logic [0:8] p;
        for (int t = 0; t < 9; t++) p[t] = ^(m & PMASK[t]);
        return p;
    endfunction

    function automatic logic [0:8] m_syn(input logic [0:24] c);
        return c[16:24] ^ m_parity(c[0:15]);
    endfunction

    function automatic logic [0:24] m_encode(input logic [0:15] m);
        return {m, m_parity(m)};
    endfunction

    function automatic void m_decode(input logic [0:24] c, output logic [0:15] msg,
                                     output logic corr, output logic unc, output int lat);
        logic [0:8]  s;
        logic [0:8]  diff;
        logic [0:24] e;
        logic        found;
        int          lo;
        int          hi;
        s     = m_syn(c);
        msg   = c[0:15];
        corr  = 1'b0;
        unc   = 1'b0;
        found = 1'b0;
        lat   = (s == 9'd0) ? 2 : 18;
        if (s != 9'd0) begin
            for (int j = 0; j < 16; j++) begin
                if (!found) begin
                    e = 25'd0;
                    for (int i = j; i <= j + 3; i++) if (i <= 19) e[i] = s[i % 4];
                    diff = m_syn(e) ^ s;
                    for (int t = 0; t < 9; t++) if (20 + t >= j && 20 + t <= j + 3) diff[t] = 1'b0;
                    if (diff == 9'd0) begin
                        found = 1'b1;
                        corr  = 1'b1;
                        msg   = c[0:15] ^ e[0:15];
                    end
                end
            end
            if (!found) begin
                lo = 99;
                hi = -1;
                for (int t = 0; t < 9; t++) if (s[t]) begin
                    if (lo == 99) lo = t;
                    hi = t;
                end
                if (hi - lo <= 3) corr = 1'b1;
                else unc = 1'b1;
            end
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [0:24] c, input bit gaps);
        int  i;
        int  guard;
        bit  acc;
        i     = 0;
        guard = 0;
        while (i < 25 && guard < 500) begin
            if (gaps && ($urandom_range(3, 0) == 0)) begin
                bus_if.in_valid = 1'b0;
                bus_if.in_bit   = 1'($urandom_range(1, 0));
            end else begin
                bus_if.in_valid = 1'b1;
                bus_if.in_bit   = c[i];
            end
            acc = bus_if.in_valid && bus_if.in_ready;
            step();
            if (acc) i++;
            guard++;
        end
        bus_if.in_valid = 1'b0;
        check("send_beats", 32'(i), 32'd25);
    endtask

    task automatic run(input string tag, input logic [0:24] c, input logic [0:15] e_msg,
                       input logic e_corr, input logic e_unc, input int e_lat,
                       input bit gaps, input int hold);
        int lat;
        send(c, gaps);
        lat = 1;
        while (!bus_if.out_valid && lat < 40) begin
            bus_if.in_valid = 1'($urandom_range(1, 0));
            bus_if.in_bit   = 1'($urandom_range(1, 0));
            step();
            lat++;
        end
        bus_if.in_valid = 1'b0;
        check({tag, "_latency"}, 32'(lat), 32'(e_lat));
        check({tag, "_msg"}, 32'(bus_if.out_msg), 32'(e_msg));
        check({tag, "_flags"}, 32'({bus_if.out_corrected, bus_if.out_uncorrectable}),
              32'({e_corr, e_unc}));
        check({tag, "_in_ready_low"}, 32'(bus_if.in_ready), 32'd0);
        for (int k = 0; k < hold; k++) begin
            step();
            check({tag, "_hold"},
                  32'({bus_if.out_valid, bus_if.in_ready, bus_if.out_msg,
                       bus_if.out_corrected, bus_if.out_uncorrectable}),
                  32'({1'b1, 1'b0, e_msg, e_corr, e_unc}));
        end
        bus_if.out_ready = 1'b1;
        step();
        bus_if.out_ready = 1'b0;
        check({tag, "_handshake"}, 32'({bus_if.out_valid, bus_if.in_ready}), 32'b01);
    endtask

    initial begin
        logic [0:24] c;
        logic [0:15] m;
        logic [0:15] xm;
        logic        xc;
        logic        xu;
        int          xl;
        int          pos;
        int          len;
        logic [3:0]  pat;

        rst              = 1'b1;
        bus_if.in_bit    = 1'b0;
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        check("reset_state",
              32'({bus_if.in_ready, bus_if.out_valid, bus_if.out_msg,
                   bus_if.out_corrected, bus_if.out_uncorrectable}),
              32'({1'b1, 1'b0, 16'h0000, 1'b0, 1'b0}));

        run("clean_ffff", m_encode(16'hFFFF), 16'hFFFF, 1'b0, 1'b0, 2, 1'b0, 0);

        c = 25'd0;
        c[0:3] = 4'b1111;
        check("synd_burst0", 32'(m_syn(c)), 32'(9'b111100010));
        run("burst_head", c, 16'h0000, 1'b1, 1'b0, 18, 1'b0, 0);

        c = m_encode(16'hFFFF);
        c[21:24] = 4'b0000;
        run("parity_burst", c, 16'hFFFF, 1'b1, 1'b0, 18, 1'b0, 0);

        c = 25'd0;
        c[2]  = 1'b1;
        c[14] = 1'b1;
        run("uncorrectable", c, 16'h2002, 1'b0, 1'b1, 18, 1'b0, 10);

        for (int i = 0; i < 12; i++) begin
            bus_if.in_valid = 1'b1;
            bus_if.in_bit   = 1'($urandom_range(1, 0));
            step();
        end
        bus_if.in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_mid_shift", 32'({bus_if.in_ready, bus_if.out_valid}), 32'b10);
        run("after_rst", m_encode(16'hA5A5), 16'hA5A5, 1'b0, 1'b0, 2, 1'b1, 0);

        c = m_encode(16'h1234);
        c[5] = ~c[5];
        send(c, 1'b0);
        for (int i = 0; i < 6; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_mid_search", 32'({bus_if.in_ready, bus_if.out_valid}), 32'b10);
        run("after_rst2", m_encode(16'h0F0F), 16'h0F0F, 1'b0, 1'b0, 2, 1'b0, 0);

        for (int r = 0; r < 30; r++) begin
            m = 16'($urandom);
            c = m_encode(m);
            case ($urandom_range(2, 0))
                0: ;
                1: begin
                    pos = int'($urandom_range(24, 0));
                    len = int'($urandom_range(4, 1));
                    pat = 4'($urandom_range(15, 0)) | 4'b1000;
                    for (int k = 0; k < len; k++) if (pos + k <= 24) c[pos + k] = c[pos + k] ^ pat[3 - k];
                end
                default: begin
                    pos = int'($urandom_range(24, 0));
                    c[pos] = ~c[pos];
                    pos = int'($urandom_range(24, 0));
                    c[pos] = ~c[pos];
                end
            endcase
            m_decode(c, xm, xc, xu, xl);
            run("random", c, xm, xc, xu, xl, 1'b1, int'($urandom_range(3, 0)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
